// File: rtl/cosim_commit_fifo.sv
// cosim_commit_fifo
//   Per-hart producer for the Spike co-simulation checker. Captures retired
//   instructions from the core commit port (and, optionally, mip changes as
//   interrupt marker records). Buffers them in order in a first-word-fall-through
//   circular buffer. Presents the head record through a valid/ready pop port.
//
//   Optional feature macro: COSIM_COMMIT_IRQ_MARKER_EN
//     defined   : mip change detection; a marker record is pushed ahead of any
//                 same-cycle commit (up to two pushes per cycle).
//     undefined : irq_mip_i is ignored; out_is_irq_o and out_mip_o are tied 0.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   commit_*_i                 retirement event (valid, pc, ins, dst, wr, data, xcpt, cause)
//   irq_mip_i                  current mip from the core
//   flush_i                    synchronous clear of all records, seq and overflow
//   out_valid_o / out_ready_i  head record handshake
//   out_*_o                    head record fields (0 while empty)
//   count_o                    occupancy 0..DEPTH
//   overflow_o                 sticky: a push set was dropped
//   hart_id_o                  constant HART_ID
module cosim_commit_fifo #(
  parameter int DEPTH   = 8,
  parameter int XLEN    = 64,
  parameter int HART_ID = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     commit_valid_i,
  input  logic [XLEN-1:0]          commit_pc_i,
  input  logic [31:0]              commit_ins_i,
  input  logic [4:0]               commit_dst_i,
  input  logic                     commit_wr_valid_i,
  input  logic [XLEN-1:0]          commit_data_i,
  input  logic                     commit_xcpt_i,
  input  logic [XLEN-1:0]          commit_xcpt_cause_i,
  input  logic [XLEN-1:0]          irq_mip_i,
  input  logic                     flush_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     out_is_irq_o,
  output logic [XLEN-1:0]          out_pc_o,
  output logic [31:0]              out_ins_o,
  output logic [4:0]               out_dst_o,
  output logic                     out_wr_valid_o,
  output logic [XLEN-1:0]          out_data_o,
  output logic                     out_xcpt_o,
  output logic [XLEN-1:0]          out_xcpt_cause_o,
  output logic [XLEN-1:0]          out_mip_o,
  output logic [31:0]              out_seq_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o,
  output logic [31:0]              hart_id_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Commit-info record; marker-only fields live in separate arrays so the
  // default build carries no dead storage.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     ins;
    logic [4:0]      dst;
    logic            wr_valid;
    logic [XLEN-1:0] data;
    logic            xcpt;
    logic [XLEN-1:0] cause;
    logic [31:0]     seq;
  } rec_t;

  rec_t            rec_mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr, cm_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     seq;
  logic            overflow;

  logic            pop;
  logic            irq_chg;
  logic [1:0]      n_push;
  logic [CW:0]     free_slots;
  logic            drop;
  logic            accept;
  rec_t            commit_rec;
  rec_t            marker_rec;
  rec_t            head;

  // ---------------------------------------------------------------------------
  // Push / pop decision
  // ---------------------------------------------------------------------------
`ifdef COSIM_COMMIT_IRQ_MARKER_EN
  logic [XLEN-1:0] mip_prev;
  logic            irq_mem [DEPTH];
  logic [XLEN-1:0] mip_mem [DEPTH];

  assign irq_chg = (irq_mip_i != mip_prev);

  // mip_prev tracks the core every cycle, even when the marker is dropped or
  // flushed, so a lost change is not re-reported later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mip_prev <= '0;
    else        mip_prev <= irq_mip_i;
  end
`else
  logic unused_irq_mip;
  assign unused_irq_mip = ^irq_mip_i;
  assign irq_chg        = 1'b0;
`endif

  assign out_valid_o = (count != '0);
  assign pop         = out_valid_o && out_ready_i;
  assign n_push      = {1'b0, irq_chg} + {1'b0, commit_valid_i};

  // A same-cycle pop frees a slot. The whole push set is dropped when it does
  // not fit: a marker is never split from its commit.
  assign free_slots  = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop);
  assign drop        = !flush_i && ((CW+1)'(n_push) > free_slots);
  assign accept      = !flush_i && (n_push != 2'd0) && !drop;

  // Marker takes the lower slot, so the commit lands one slot (and one seq) later.
  assign cm_ptr      = wr_ptr + AW'(irq_chg);

  always_comb begin
    commit_rec          = '0;
    commit_rec.pc       = commit_pc_i;
    commit_rec.ins      = commit_ins_i;
    commit_rec.dst      = commit_dst_i;
    commit_rec.wr_valid = commit_wr_valid_i;
    commit_rec.data     = commit_data_i;
    commit_rec.xcpt     = commit_xcpt_i;
    commit_rec.cause    = commit_xcpt_cause_i;
    commit_rec.seq      = seq + 32'(irq_chg);
    marker_rec          = '0;
    marker_rec.seq      = seq;
  end

  // ---------------------------------------------------------------------------
  // Storage: writes only touch free slots, so the head is never disturbed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      if (irq_chg) begin
        rec_mem[wr_ptr] <= marker_rec;
`ifdef COSIM_COMMIT_IRQ_MARKER_EN
        irq_mem[wr_ptr] <= 1'b1;
        mip_mem[wr_ptr] <= irq_mip_i;
`endif
      end
      if (commit_valid_i) begin
        rec_mem[cm_ptr] <= commit_rec;
`ifdef COSIM_COMMIT_IRQ_MARKER_EN
        irq_mem[cm_ptr] <= 1'b0;
        mip_mem[cm_ptr] <= '0;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy, sequence counter, sticky overflow
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      seq      <= '0;
      overflow <= 1'b0;
    end else if (flush_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      seq      <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (accept) begin
        wr_ptr <= wr_ptr + AW'(n_push);
        seq    <= seq + 32'(n_push);
      end
      count <= count + (accept ? CW'(n_push) : CW'(0)) - CW'(pop);
      if (drop) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Head presentation (zeroed while empty)
  // ---------------------------------------------------------------------------
  assign head             = rec_mem[rd_ptr];
  assign out_pc_o         = out_valid_o ? head.pc       : '0;
  assign out_ins_o        = out_valid_o ? head.ins      : '0;
  assign out_dst_o        = out_valid_o ? head.dst      : '0;
  assign out_wr_valid_o   = out_valid_o ? head.wr_valid : 1'b0;
  assign out_data_o       = out_valid_o ? head.data     : '0;
  assign out_xcpt_o       = out_valid_o ? head.xcpt     : 1'b0;
  assign out_xcpt_cause_o = out_valid_o ? head.cause    : '0;
  assign out_seq_o        = out_valid_o ? head.seq      : '0;
`ifdef COSIM_COMMIT_IRQ_MARKER_EN
  assign out_is_irq_o     = out_valid_o ? irq_mem[rd_ptr] : 1'b0;
  assign out_mip_o        = out_valid_o ? mip_mem[rd_ptr] : '0;
`else
  assign out_is_irq_o     = 1'b0;
  assign out_mip_o        = '0;
`endif

  assign count_o    = count;
  assign overflow_o = overflow;
  assign hart_id_o  = 32'(HART_ID);

endmodule

// File: tb/tb_cosim_commit_fifo.sv
// Scoreboard bench for cosim_commit_fifo (DEPTH=8, XLEN=64, HART_ID=3).
// Stimulus pushes expected records into exp_q; the monitor pops and compares
// on every handshake, sampled on the falling edge.
module tb_cosim_commit_fifo;
  localparam int DEPTH = 8;
  localparam int XLEN  = 64;

  typedef struct packed {
    logic            is_irq;
    logic [XLEN-1:0] pc;
    logic [31:0]     ins;
    logic [4:0]      dst;
    logic            wr;
    logic [XLEN-1:0] data;
    logic            xcpt;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] mip;
    logic [31:0]     seq;
  } rec_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            commit_valid_i, commit_wr_valid_i, commit_xcpt_i;
  logic [XLEN-1:0] commit_pc_i, commit_data_i, commit_xcpt_cause_i, irq_mip_i;
  logic [31:0]     commit_ins_i;
  logic [4:0]      commit_dst_i;
  logic            flush_i, out_ready_i;
  logic            out_valid_o, out_is_irq_o, out_wr_valid_o, out_xcpt_o, overflow_o;
  logic [XLEN-1:0] out_pc_o, out_data_o, out_xcpt_cause_o, out_mip_o;
  logic [31:0]     out_ins_o, out_seq_o, hart_id_o;
  logic [4:0]      out_dst_o;
  logic [3:0]      count_o;

  int checks = 0;
  int errors = 0;
  rec_t exp_q[$];

  always #5 clk = ~clk;

  cosim_commit_fifo #(.DEPTH(DEPTH), .XLEN(XLEN), .HART_ID(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i), .commit_ins_i(commit_ins_i),
    .commit_dst_i(commit_dst_i), .commit_wr_valid_i(commit_wr_valid_i),
    .commit_data_i(commit_data_i), .commit_xcpt_i(commit_xcpt_i),
    .commit_xcpt_cause_i(commit_xcpt_cause_i), .irq_mip_i(irq_mip_i), .flush_i(flush_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_is_irq_o(out_is_irq_o),
    .out_pc_o(out_pc_o), .out_ins_o(out_ins_o), .out_dst_o(out_dst_o),
    .out_wr_valid_o(out_wr_valid_o), .out_data_o(out_data_o), .out_xcpt_o(out_xcpt_o),
    .out_xcpt_cause_o(out_xcpt_cause_o), .out_mip_o(out_mip_o), .out_seq_o(out_seq_o),
    .count_o(count_o), .overflow_o(overflow_o), .hart_id_o(hart_id_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head record is compared against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      rec_t act, exp;
      act = '{out_is_irq_o, out_pc_o, out_ins_o, out_dst_o, out_wr_valid_o, out_data_o,
              out_xcpt_o, out_xcpt_cause_o, out_mip_o, out_seq_o};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got seq %0d pc 0x%0h, expected nothing", out_seq_o, out_pc_o);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL record: got irq=%0b pc=0x%0h seq=%0d mip=0x%0h data=0x%0h dst=%0d; expected irq=%0b pc=0x%0h seq=%0d mip=0x%0h data=0x%0h dst=%0d",
                   act.is_irq, act.pc, act.seq, act.mip, act.data, act.dst,
                   exp.is_irq, exp.pc, exp.seq, exp.mip, exp.data, exp.dst);
        end
      end
    end
  end

  // Record payload derived from the pc so each entry is distinguishable.
  function automatic rec_t mk_commit(input logic [63:0] pc, input logic [31:0] sq);
    rec_t r = '0;
    r.pc    = pc;
    r.ins   = 32'h0000_0013;
    r.dst   = pc[6:2];
    r.wr    = ~pc[2];
    r.data  = {32'hDA7A_0000, pc[31:0]};
    r.xcpt  = pc[4];
    r.cause = pc[4] ? 64'd2 : 64'd0;
    r.seq   = sq;
    return r;
  endfunction

  // Called just after a rising edge; occupies one cycle.
  task automatic commit(input logic [63:0] pc, input bit acc, input logic [31:0] sq);
    rec_t r = mk_commit(pc, sq);
    commit_valid_i = 1'b1;  commit_pc_i = r.pc;  commit_ins_i = r.ins;
    commit_dst_i = r.dst;   commit_wr_valid_i = r.wr;  commit_data_i = r.data;
    commit_xcpt_i = r.xcpt; commit_xcpt_cause_i = r.cause;
    if (acc) exp_q.push_back(r);
    @(posedge clk); #1;
    commit_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic flush();
    out_ready_i = 1'b0;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    int n = 0;
    out_ready_i = 1'b1;
    while (count_o != 0 && n < 40) begin @(posedge clk); #1; n++; end
    out_ready_i = 1'b0;
    chk({name, "_drained_count"}, 64'(count_o), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; commit_valid_i = 1'b0; commit_pc_i = '0; commit_ins_i = '0;
    commit_dst_i = '0; commit_wr_valid_i = 1'b0; commit_data_i = '0; commit_xcpt_i = 1'b0;
    commit_xcpt_cause_i = '0; irq_mip_i = '0; flush_i = 1'b0; out_ready_i = 1'b0;
    idle(3);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_overflow", 64'(overflow_o), 64'd0);
    chk("rst_pc_zero", out_pc_o, 64'd0);
    chk("rst_seq_zero", 64'(out_seq_o), 64'd0);
    chk("hart_id", 64'(hart_id_o), 64'd3);
    rst_n = 1'b1;
    idle(1);

    // Three in-order commits with the checker always ready.
    out_ready_i = 1'b1;
    commit(64'h8000_0000, 1, 0);
    commit(64'h8000_0004, 1, 1);
    commit(64'h8000_0008, 1, 2);
    idle(3);
    chk("t1_count", 64'(count_o), 64'd0);
    chk("t1_overflow", 64'(overflow_o), 64'd0);

    // mip change plus commit in the same cycle.
    flush();
    irq_mip_i = 64'h800;
`ifdef COSIM_COMMIT_IRQ_MARKER_EN
    begin
      rec_t m = '0;
      m.is_irq = 1'b1; m.mip = 64'h800; m.seq = 0;
      exp_q.push_back(m);
    end
    commit(64'h8000_0010, 1, 1);
    chk("t2_count", 64'(count_o), 64'd2);
    chk("t2_head_is_irq", 64'(out_is_irq_o), 64'd1);
    chk("t2_head_mip", out_mip_o, 64'h800);
`else
    commit(64'h8000_0010, 1, 0);
    chk("t2_count", 64'(count_o), 64'd1);
    chk("t2_head_is_irq", 64'(out_is_irq_o), 64'd0);
    chk("t2_head_mip", out_mip_o, 64'd0);
`endif
    drain("t2");

    // Fill to DEPTH, then pop+push at full, then a dropped commit.
    flush();
    for (int i = 0; i < DEPTH; i++) commit(64'h8000_1000 + 64'(4*i), 1, 32'(i));
    chk("t3_full_count", 64'(count_o), 64'd8);
    chk("t3_full_overflow", 64'(overflow_o), 64'd0);
    chk("t3_head_seq", 64'(out_seq_o), 64'd0);
    out_ready_i = 1'b1;
    commit(64'h8000_2000, 1, 8);
    out_ready_i = 1'b0;
    chk("t4_popush_count", 64'(count_o), 64'd8);
    chk("t4_popush_overflow", 64'(overflow_o), 64'd0);
    chk("t4_head_seq", 64'(out_seq_o), 64'd1);
    commit(64'h8000_3000, 0, 0);
    chk("t3_drop_count", 64'(count_o), 64'd8);
    chk("t3_drop_overflow", 64'(overflow_o), 64'd1);
    drain("t3");
    chk("t3_sticky_overflow", 64'(overflow_o), 64'd1);
    commit(64'h8000_3004, 1, 9);
    drain("t3b");

    // Seven held, then a push set that does not fit.
    flush();
    chk("t5_flush_overflow", 64'(overflow_o), 64'd0);
    for (int i = 0; i < 7; i++) commit(64'h8000_4000 + 64'(4*i), 1, 32'(i));
    chk("t5_count7", 64'(count_o), 64'd7);
`ifdef COSIM_COMMIT_IRQ_MARKER_EN
    irq_mip_i = 64'h880;
    commit(64'h8000_5000, 0, 0);
    chk("t5_pair_drop_count", 64'(count_o), 64'd7);
`else
    commit(64'h8000_401c, 1, 7);
    chk("t5_fill_count", 64'(count_o), 64'd8);
    commit(64'h8000_5000, 0, 0);
    chk("t5_drop_count", 64'(count_o), 64'd8);
`endif
    chk("t5_overflow", 64'(overflow_o), 64'd1);
    flush();
    chk("t5_after_flush_count", 64'(count_o), 64'd0);
    chk("t5_after_flush_overflow", 64'(overflow_o), 64'd0);
    commit(64'h8000_6000, 1, 0);
    drain("t5");

    // Asynchronous reset with five records held.
    for (int i = 0; i < 5; i++) commit(64'h8000_7000 + 64'(4*i), 1, 32'(i + 1));
    chk("t6_count5", 64'(count_o), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(out_valid_o), 64'd0);
    chk("t6_async_count", 64'(count_o), 64'd0);
    exp_q.delete();
    irq_mip_i = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    commit(64'h8000_8000, 1, 0);
    drain("t6");

    idle(2);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
